// File: rtl/system_sysinfo_if.sv
// Avalon-MM slave bus for the system-information block.
// The master drives requests and the slave returns pipelined read data.
interface system_sysinfo_if #(
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/system_sysinfo.sv
// System-information slave: ID, build timestamp, 64-bit cycle counter with a
// coherent high-word snapshot, seconds counter, scratch word and counter clear.
module system_sysinfo #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  system_sysinfo_if.slave  bus
);

  localparam int unsigned PRESC_W = $clog2(CLK_FREQ_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [63:0]        cyc;
  logic [31:0]        snap_hi;
  logic [31:0]        seconds;
  logic [31:0]        scratch;
  logic [PRESC_W-1:0] presc_left;

  logic        addr_in_map;
  logic [2:0]  word;
  logic        rd_acc;
  logic        wr_acc;
  logic        clear;
  logic [31:0] rd_word;

  logic [31:0]             pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;

  // Any set address bit above the eight-word map takes the request out of the map.
  assign addr_in_map = (bus.address >> 3) == '0;
  assign word        = bus.address[2:0];
  assign wr_acc      = bus.write && addr_in_map;
  assign rd_acc      = bus.read && !bus.write;
  assign clear       = wr_acc && (word == 3'd6) && bus.byteenable[0] && bus.writedata[0];

  always_comb begin
    rd_word = '0;
    if (addr_in_map) begin
      case (word)
        3'd0:    rd_word = SYSTEM_ID;
        3'd1:    rd_word = TIMESTAMP;
        3'd2:    rd_word = cyc[31:0];
        3'd3:    rd_word = snap_hi;
        3'd4:    rd_word = seconds;
        3'd5:    rd_word = scratch;
        default: rd_word = '0;
      endcase
    end
  end

  // Prescaler is a down-counter: cycles left until the next seconds tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc        <= '0;
      snap_hi    <= '0;
      seconds    <= '0;
      presc_left <= PRESC_LOAD;
    end else if (clear) begin
      cyc        <= '0;
      snap_hi    <= '0;
      seconds    <= '0;
      presc_left <= PRESC_LOAD;
    end else begin
      cyc <= cyc + 64'd1;
      if (presc_left == '0) begin
        presc_left <= PRESC_LOAD;
        seconds    <= seconds + 32'd1;
      end else begin
        presc_left <= presc_left - 1'b1;
      end
      if (rd_acc && addr_in_map && (word == 3'd2)) snap_hi <= cyc[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
    end else if (wr_acc && (word == 3'd5)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
  end

  // Data stages carry zero when empty so readdata is 0 outside readdatavalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0]  <= rd_acc;
      pipe_data[0] <= rd_acc ? rd_word : '0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign bus.readdata      = pipe_data[READ_LATENCY-1];
  assign bus.readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_system_sysinfo.sv
// Randomized bench for system_sysinfo against a cycle-count based reference model.
module tb_system_sysinfo;

  localparam int unsigned AW   = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned FREQ = 10;
  localparam logic [31:0] SID  = 32'h5151_0001;
  localparam logic [31:0] TS   = 32'h6600_1234;
  localparam logic [31:0] SINIT = 32'hDEAD_BEEF;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  system_sysinfo_if #(.ADDR_W(AW)) bus ();

  system_sysinfo #(
    .SYSTEM_ID(SID), .TIMESTAMP(TS), .ADDR_W(AW),
    .READ_LATENCY(LAT), .CLK_FREQ_HZ(FREQ), .SCRATCH_INIT(SINIT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: counters as plain numbers of elapsed cycles.
  typedef struct {
    longint      due;
    logic [31:0] d;
  } rd_t;

  rd_t         q[$];
  longint      edge_n = 0;
  logic [63:0] m_cyc;
  logic [63:0] m_ticks;
  logic [31:0] m_snap;
  logic [31:0] m_scratch;

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    logic [63:0] secs;
    secs = m_ticks / 64'(FREQ);
    case (a)
      0:       return SID;
      1:       return TS;
      2:       return m_cyc[31:0];
      3:       return m_snap;
      4:       return secs[31:0];
      5:       return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    rd_t e;
    bus.read = rd; bus.write = wr; bus.address = a;
    bus.byteenable = be; bus.writedata = wd;
    edge_n++;
    if (rd && !wr) begin
      e.due = edge_n + LAT - 1;
      e.d   = m_read(a);
      q.push_back(e);
      if (a == 2) m_snap = m_cyc[63:32];
    end
    if (wr && a == 5) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
    end
    if (wr && a == 6 && be[0] && wd[0]) begin
      m_cyc = 0; m_ticks = 0; m_snap = 0;
    end else begin
      m_cyc++; m_ticks++;
    end
    @(negedge clock);
    begin
      logic        ev;
      logic [31:0] ed;
      ev = 1'b0; ed = 32'h0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        ev = 1'b1; ed = q[0].d;
        void'(q.pop_front());
      end
      check("readdatavalid", 64'(bus.readdatavalid), 64'(ev));
      check("readdata", 64'(bus.readdata), 64'(ed));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1, 0, a, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
    step(0, 1, a, be, wd);
  endtask

  task automatic do_reset();
    bus.read = 0; bus.write = 0; bus.address = '0; bus.byteenable = '0; bus.writedata = '0;
    reset_n = 1'b0;
    q.delete();
    m_cyc = 0; m_ticks = 0; m_snap = 0; m_scratch = SINIT;
    @(negedge clock);
    check("rst_readdatavalid", 64'(bus.readdatavalid), 64'h0);
    check("rst_readdata", 64'(bus.readdata), 64'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.read = 0; bus.write = 0; bus.address = '0; bus.byteenable = '0; bus.writedata = '0;
    @(negedge clock);
    do_reset();

    // ID and timestamp back to back, then reset-state counters and scratch
    rd(0); rd(1); idle(3);
    rd(3); rd(5); rd(4); idle(3);

    // Coherent high-word snapshot across a low-word carry
    force dut.cyc = 64'h0000_0001_FFFF_FFFF;
    #1 release dut.cyc;
    m_cyc = 64'h0000_0001_FFFF_FFFF;
    for (int i = 0; i < 10 && m_cyc != 64'h0000_0002_0000_0003; i++) idle(1);
    check("cyc_reach_target", m_cyc, 64'h0000_0002_0000_0003);
    rd(2); idle(7); rd(3); idle(3);

    // Seconds counting and counter clear
    do_reset();
    idle(35);
    rd(4);
    wr(6, 4'b0001, 32'h1);
    rd(4); rd(2); idle(3);

    // Scratch byte lanes and read-only words
    wr(5, 4'b1111, 32'hAABBCCDD);
    wr(5, 4'b0101, 32'h11223344);
    rd(5);
    wr(0, 4'b1111, 32'hFFFF_FFFF);
    rd(0); idle(3);

    // Simultaneous read/write, unmapped and out-of-range addresses
    step(1, 1, 5, 4'b1111, 32'h5); idle(2);
    rd(5); rd(7); rd(8);
    wr(13, 4'b1111, 32'h0);
    rd(5);
    wr(14, 4'b0001, 32'h1);
    rd(2); idle(3);

    // Reset while reads are in flight
    rd(0); rd(1); rd(5);
    do_reset();
    rd(2); rd(5); idle(4);

    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           AW'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
